data_memory_sized: RTL and testbench

//  Parametrised RV32 data memory with a valid/ready request and response interface.

---
 rtl/data_memory_sized.sv | 172 +++++++++++++++++
 tb/tb_data_memory_sized.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// RV32 data memory with valid/ready request/response, byte/half/word access, configurable
// read latency and fault detection for misaligned, out-of-range and illegal accesses.
module data_memory_sized #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW      = 3;
  localparam bit          MultiCyc  = (RD_LAT > 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_q, pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              illegal, misal, out_of_range, acc_err;
  logic [IdxW-1:0]   word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_data;
  logic [3:0]        be;
  logic [31:0]       wr_data;
  logic              mem_we;

  assign req_ready = (state_q != StWait);
  assign accept    = req_valid & req_ready;
  assign word_idx  = req_addr[IdxW+1:2];
  assign rd_word   = mem_q[word_idx];

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  misal = req_addr[0];
      3'b010:  misal = |req_addr[1:0];
      3'b100:  illegal = req_we;
      3'b101: begin
        illegal = req_we;
        misal   = req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign out_of_range = {2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);
  assign acc_err      = illegal | misal | out_of_range;

  // Load extraction: lane select, then sign or zero extension.
  always_comb begin
    byte_sel = rd_word[{req_addr[1:0], 3'b000} +: 8];
    half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  assign mem_we = accept & req_we & ~acc_err;

  // Array contents survive reset; reset only blocks writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (MultiCyc && !req_we && !acc_err) begin
            state_d = StWait;
            cnt_d   = CntW'(RD_LAT - 1);
            pend_d  = ld_data;
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (!req_we && !acc_err) ? ld_data : 32'h0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pend_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: one instance at RD_LAT=1 (a_*) and one at RD_LAT=3 (b_*).
module tb_data_memory_sized;

  logic        clk;
  logic        rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [2:0]  a_req_funct3;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [2:0]  b_req_funct3;

  int          n_cmp;
  int          n_mis;
  logic [31:0] rd;
  logic        er;
  int          lat;

  data_memory_sized #(.DEPTH_WORDS(256), .RD_LAT(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_funct3(a_req_funct3),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  data_memory_sized #(.DEPTH_WORDS(256), .RD_LAT(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_funct3(b_req_funct3),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction on instance a (sel=0) or b (sel=1); leaves rd/er/lat (lat=0: no response).
  task automatic tx(input bit sel, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] wd);
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_funct3 = f3; b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_funct3 = f3; a_req_wdata = wd;
    end
    for (int i = 0; i < 10 && !(sel ? b_req_ready : a_req_ready); i++) @(negedge clk);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (sel ? b_rsp_valid : a_rsp_valid) begin
        rd  = sel ? b_rsp_rdata : a_rsp_rdata;
        er  = sel ? b_rsp_err : a_rsp_err;
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready got %b want 1", a_req_ready); end
    n_cmp++; if (a_rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %b want 0", a_rsp_valid); end
    n_cmp++; if (a_rsp_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_rdata got %h want 0", a_rsp_rdata); end
    n_cmp++; if (a_rsp_err !== 1'b0) begin n_mis++; $display("FAIL rst_err got %b want 0", a_rsp_err); end
    n_cmp++; if (b_req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready3 got %b want 1", b_req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    tx(0, 1, 32'h3C0, 3'b010, 32'h55555555);
    n_cmp++; if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin n_mis++; $display("FAIL sw_3c0 got lat=%0d err=%b rd=%h want lat=1 err=0 rd=0", lat, er, rd); end
    tx(0, 0, 32'h3C0, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h55555555) begin n_mis++; $display("FAIL lw_3c0 got %h want 55555555", rd); end
    n_cmp++; if (lat !== 1 || er !== 1'b0) begin n_mis++; $display("FAIL lw_3c0_lat got lat=%0d err=%b want 1/0", lat, er); end
    tx(1, 1, 32'h3C0, 3'b010, 32'h55555555);
    n_cmp++; if (lat !== 1 || er !== 1'b0) begin n_mis++; $display("FAIL sw3_3c0 got lat=%0d err=%b want 1/0", lat, er); end
    tx(1, 0, 32'h3C0, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h55555555 || lat !== 3) begin n_mis++; $display("FAIL lw3_3c0 got rd=%h lat=%0d want 55555555/3", rd, lat); end
    tx(0, 1, 32'h3FC, 3'b010, 32'h13579BDF);
    tx(0, 0, 32'h3FC, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h13579BDF || er !== 1'b0) begin n_mis++; $display("FAIL lw_top got rd=%h err=%b want 13579bdf/0", rd, er); end
  endtask

  task automatic test_byte();
    tx(0, 1, 32'h10, 3'b010, 32'h0);
    tx(0, 1, 32'h12, 3'b000, 32'hFFFFFF80);
    tx(0, 0, 32'h12, 3'b000, 32'h0);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_mis++; $display("FAIL lb_12 got %h want ffffff80", rd); end
    tx(0, 0, 32'h12, 3'b100, 32'h0);
    n_cmp++; if (rd !== 32'h00000080) begin n_mis++; $display("FAIL lbu_12 got %h want 00000080", rd); end
    tx(0, 0, 32'h10, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h00800000) begin n_mis++; $display("FAIL lw_10 got %h want 00800000", rd); end
  endtask

  task automatic test_half();
    tx(0, 1, 32'h20, 3'b010, 32'h0);
    tx(0, 1, 32'h22, 3'b001, 32'h1234BEEF);
    tx(0, 0, 32'h22, 3'b001, 32'h0);
    n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_mis++; $display("FAIL lh_22 got %h want ffffbeef", rd); end
    tx(0, 0, 32'h22, 3'b101, 32'h0);
    n_cmp++; if (rd !== 32'h0000BEEF) begin n_mis++; $display("FAIL lhu_22 got %h want 0000beef", rd); end
    tx(0, 0, 32'h21, 3'b001, 32'h0);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin n_mis++; $display("FAIL lh_21 got err=%b rd=%h lat=%0d want 1/0/1", er, rd, lat); end
    tx(0, 0, 32'h20, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'hBEEF0000) begin n_mis++; $display("FAIL lw_20 got %h want beef0000", rd); end
  endtask

  task automatic test_errors();
    tx(0, 1, 32'h0C, 3'b010, 32'hA5A5A5A5);
    tx(0, 1, 32'h0F, 3'b010, 32'h12345678);
    n_cmp++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_mis++; $display("FAIL sw_0f got err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
    tx(0, 1, 32'h0E, 3'b001, 32'h0000FFFF);
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL sh_0e got err=%b want 0", er); end
    tx(0, 1, 32'h0D, 3'b001, 32'h00001111);
    n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL sh_0d got err=%b want 1", er); end
    tx(0, 1, 32'h0C, 3'b100, 32'h0);
    n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL st_f100 got err=%b want 1", er); end
    tx(0, 0, 32'h0C, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'hFFFFA5A5) begin n_mis++; $display("FAIL lw_0c got %h want ffffa5a5", rd); end
    tx(0, 1, 32'h400, 3'b010, 32'h77777777);
    n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_mis++; $display("FAIL sw_400 got err=%b lat=%0d want 1/1", er, lat); end
    tx(0, 0, 32'h0, 3'b011, 32'h0);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_mis++; $display("FAIL f3_011 got err=%b rd=%h want 1/0", er, rd); end
    tx(1, 0, 32'h404, 3'b010, 32'h0);
    n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_mis++; $display("FAIL lw3_404 got err=%b lat=%0d want 1/1", er, lat); end
    tx(0, 0, 32'h3C0, 3'b110, 32'h0);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_mis++; $display("FAIL f3_110 got err=%b rd=%h want 1/0", er, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [31:0] seen [4];
    int          got;
    int          lowc;
    int          idx;
    logic        acc;
    vals[0] = 32'hA0000001; vals[1] = 32'hB0000002;
    vals[2] = 32'hC0000003; vals[3] = 32'hD0000004;
    for (int i = 0; i < 4; i++) begin
      tx(1, 1, 32'h100 + 32'(4 * i), 3'b010, vals[i]);
      seen[i] = 32'h0;
    end
    got = 0; lowc = 0; idx = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h100;
    for (int c = 0; c < 18; c++) begin
      if (b_rsp_valid) begin
        if (got < 4) seen[got] = b_rsp_rdata;
        got++;
      end
      if (!b_req_ready) lowc++;
      acc = b_req_valid & b_req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == 4) b_req_valid = 1'b0;
        else b_req_addr = 32'h100 + 32'(4 * idx);
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    n_cmp++; if (got !== 4) begin n_mis++; $display("FAIL b2b3_count got %0d want 4", got); end
    n_cmp++; if (lowc !== 8) begin n_mis++; $display("FAIL b2b3_ready_low got %0d want 8", lowc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seen[i] !== vals[i]) begin n_mis++; $display("FAIL b2b3_rsp%0d got %h want %h", i, seen[i], vals[i]); end
    end
    // RD_LAT=1: store then load of the same word on consecutive edges.
    tx(0, 1, 32'h40, 3'b010, 32'h11111111);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h40; a_req_funct3 = 3'b010;
    a_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    a_req_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_req_ready !== 1'b1) begin n_mis++; $display("FAIL b2b1_sw got v=%b e=%b rdy=%b want 1/0/1", a_rsp_valid, a_rsp_err, a_req_ready); end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hCAFEF00D) begin n_mis++; $display("FAIL b2b1_lw got v=%b rd=%h want 1/cafef00d", a_rsp_valid, a_rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (a_rsp_valid !== 1'b0) begin n_mis++; $display("FAIL b2b1_pulse got %b want 0", a_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    tx(1, 1, 32'h80, 3'b010, 32'h0BADF00D);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h80; b_req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_req_ready !== 1'b0) begin n_mis++; $display("FAIL rmid_wait got ready=%b want 0", b_req_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_rst got rdy=%b v=%b want 1/0", b_req_ready, b_rsp_valid); end
    // Store presented while reset is held must not write.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0; b_req_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b_rsp_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL rmid_drop got %0d pulses want 0", pulses); end
    tx(1, 0, 32'h80, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h0BADF00D || lat !== 3) begin n_mis++; $display("FAIL rmid_lw got rd=%h lat=%0d want 0badf00d/3", rd, lat); end
    tx(0, 0, 32'h3C0, 3'b010, 32'h0);
    n_cmp++; if (rd !== 32'h55555555) begin n_mis++; $display("FAIL rmid_keep got %h want 55555555", rd); end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_funct3 = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_funct3 = '0; b_req_wdata = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
